// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite animation engine: character-state bit
// positions, animation-set encoding and small elaboration-time helpers.
package sprite_pkg;

    localparam int ST_FACE = 0;
    localparam int ST_AIR  = 1;
    localparam int ST_MOVE = 2;

    typedef enum logic [1:0] {
        SET_STAND = 2'd0,
        SET_WALK  = 2'd1,
        SET_JUMP  = 2'd2
    } anim_set_e;

    localparam logic [11:0] KEY_COLOR_DEF = 12'h000;

    // Width helper that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Airborne wins over moving; a standing character is the fallback.
    function automatic anim_set_e decode_set(input logic [2:0] st);
        if (st[ST_AIR])  return SET_JUMP;
        if (st[ST_MOVE]) return SET_WALK;
        return SET_STAND;
    endfunction

endpackage

// File: rtl/anim_timer.sv
// Animation timebase: frame tick divider, frame index sequencing, and the
// restart/hold behaviour driven by the character state.
module anim_timer
    import sprite_pkg::*;
#(
    parameter int N_FRAMES = 4,
    parameter int TICK_DIV = 6000000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [2:0]                        state,
    input  logic                              hold,
    output logic [clog2_min1(N_FRAMES)-1:0]   frame_idx,
    output anim_set_e                         anim_set
);

    localparam int FW = clog2_min1(N_FRAMES);
    localparam int TW = clog2_min1(TICK_DIV);

    anim_set_e     set_now;
    logic          face_q;
    logic          restart;
    logic          tick;
    logic [TW-1:0] tick_cnt;

    assign set_now = decode_set(state);
    assign restart = (set_now != anim_set) || (state[ST_FACE] != face_q);
    assign tick    = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            frame_idx <= '0;
            anim_set  <= SET_STAND;
            face_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let restart/tick see pre-edge values of every flop.
            anim_set <= set_now;
            face_q   <= state[ST_FACE];
            if (restart) begin
                // A new set or facing always restarts from frame 0, even while paused.
                tick_cnt  <= '0;
                frame_idx <= '0;
            end else if (!hold) begin
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                if (set_now == SET_JUMP) begin
                    frame_idx <= '0;
                end else if (tick) begin
                    frame_idx <= (frame_idx == FW'(N_FRAMES - 1)) ? '0 : frame_idx + FW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Per-character sprite engine: mirrored ROM address generation plus a
// latency-matched valid/in-range pipeline that realigns the ROM pixel.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int SPR_W    = 47,
    parameter int SPR_H    = 64,
    parameter int ADDR_W   = 14,
    parameter int N_FRAMES = 4,
    parameter int TICK_DIV = 6000000,
    parameter int ROM_LAT  = 1,
    parameter int COLOR_W  = 12,
    parameter logic [COLOR_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [2:0]                        state,
    input  logic                              hold,
    input  logic                              pix_req,
    input  logic [$clog2(SPR_W+1)-1:0]        pix_x,
    input  logic [$clog2(SPR_H+1)-1:0]        pix_y,
    output logic [ADDR_W-1:0]                 rom_addr,
    output logic [1:0]                        rom_set,
    output logic [clog2_min1(N_FRAMES)-1:0]   rom_frame,
    input  logic [COLOR_W-1:0]                rom_data,
    output logic [COLOR_W-1:0]                pix_out,
    output logic                              pix_valid,
    output logic                              pix_opaque,
    output logic [clog2_min1(N_FRAMES)-1:0]   frame_idx
);

    localparam int XW    = $clog2(SPR_W + 1);
    localparam int YW    = $clog2(SPR_H + 1);
    localparam int DEPTH = ROM_LAT + 2;

    if (SPR_W * SPR_H > 2 ** ADDR_W) begin : g_addr_chk
        $error("sprite_anim_ctrl: SPR_W*SPR_H does not fit in ADDR_W bits");
    end
    if (ROM_LAT < 1 || TICK_DIV < 2 || N_FRAMES < 1) begin : g_param_chk
        $error("sprite_anim_ctrl: ROM_LAT>=1, TICK_DIV>=2, N_FRAMES>=1 required");
    end

    anim_set_e         anim_set;
    logic              in_range;
    logic [ADDR_W-1:0] pix_addr;
    logic [DEPTH-1:0]  vld_sr;
    logic [ROM_LAT:0]  rng_sr;

    anim_timer #(
        .N_FRAMES (N_FRAMES),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .hold      (hold),
        .frame_idx (frame_idx),
        .anim_set  (anim_set)
    );

    // Left-facing sprites read each row right-to-left; only a constant multiply is needed.
    always_comb begin
        // NOTE: both outputs get a value on every path, so no latch is inferred.
        in_range = (pix_x < XW'(SPR_W)) && (pix_y < YW'(SPR_H));
        pix_addr = ADDR_W'(pix_y) * ADDR_W'(SPR_W)
                 + (state[ST_FACE] ? ADDR_W'(pix_x)
                                   : ADDR_W'(SPR_W - 1) - ADDR_W'(pix_x));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the valid pipeline is reset so pixels in flight at reset never emerge.
            rom_addr   <= '0;
            rom_set    <= '0;
            rom_frame  <= '0;
            vld_sr     <= '0;
            rng_sr     <= '0;
            pix_out    <= '0;
            pix_opaque <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[DEPTH-2:0], pix_req};
            rng_sr <= {rng_sr[ROM_LAT-1:0], in_range};

            // Set and frame are captured with the address so a later frame change cannot leak in.
            if (pix_req && in_range) begin
                rom_addr  <= pix_addr;
                rom_set   <= anim_set;
                rom_frame <= frame_idx;
            end

            if (vld_sr[ROM_LAT]) begin
                pix_out    <= rng_sr[ROM_LAT] ? rom_data : '0;
                pix_opaque <= rng_sr[ROM_LAT] && (rom_data != KEY_COLOR);
            end else begin
                pix_opaque <= 1'b0;
            end
        end
    end

    assign pix_valid = vld_sr[DEPTH-1];

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl: timer table, pixel-address table,
// back-to-back pipeline and reset-with-pixels-in-flight sequences.
`timescale 1ns/1ps
module tb_sprite_anim_ctrl;

    localparam int SPR_W    = 47;
    localparam int SPR_H    = 64;
    localparam int ADDR_W   = 14;
    localparam int N_FRAMES = 4;
    localparam int TICK_DIV = 4;
    localparam int ROM_LAT  = 1;
    localparam int COLOR_W  = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  state = 3'b000;
    logic        hold = 1'b0;
    logic        pix_req = 1'b0;
    logic [5:0]  pix_x = '0;
    logic [6:0]  pix_y = '0;
    logic [13:0] rom_addr;
    logic [1:0]  rom_set;
    logic [1:0]  rom_frame;
    logic [11:0] rom_data;
    logic [11:0] pix_out;
    logic        pix_valid;
    logic        pix_opaque;
    logic [1:0]  frame_idx;

    logic        rom_ovr_en = 1'b0;
    logic [11:0] rom_ovr_val = 12'h000;

    int n_checks = 0;
    int n_errors = 0;

    sprite_anim_ctrl #(
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .ADDR_W    (ADDR_W),
        .N_FRAMES  (N_FRAMES),
        .TICK_DIV  (TICK_DIV),
        .ROM_LAT   (ROM_LAT),
        .COLOR_W   (COLOR_W),
        .KEY_COLOR (12'h000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .hold       (hold),
        .pix_req    (pix_req),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .rom_addr   (rom_addr),
        .rom_set    (rom_set),
        .rom_frame  (rom_frame),
        .rom_data   (rom_data),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .pix_opaque (pix_opaque),
        .frame_idx  (frame_idx)
    );

    always #5 clk = ~clk;

    // Sprite ROM stand-in: every eighth address holds the key colour.
    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        return (a[2:0] == 3'd0) ? 12'h000 : (a[11:0] ^ 12'h5A5);
    endfunction

    always_ff @(posedge clk) rom_data <= rom_ovr_en ? rom_ovr_val : rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic [2:0] st;
        logic       hold;
        logic [1:0] frame;
    } tvec_t;

    typedef struct {
        logic [2:0]  st;
        logic [5:0]  x;
        logic [6:0]  y;
        logic        ovr;
        logic [11:0] ovr_val;
        logic [13:0] addr;
        logic [1:0]  set;
        logic        inr;
    } pvec_t;

    localparam int NTV = 17;
    localparam int NPV = 12;
    tvec_t tv[NTV];
    pvec_t pv[NPV];

    logic [5:0]  bx[3];
    logic [6:0]  by[3];
    logic [13:0] ba[3];

    logic [11:0] exp_out;
    logic        exp_opq;

    initial begin
        // {cycles to advance, state, hold, frame_idx expected afterwards}
        tv[0]  = '{4,  3'b100, 1'b0, 2'd0};
        tv[1]  = '{1,  3'b100, 1'b0, 2'd1};
        tv[2]  = '{4,  3'b100, 1'b0, 2'd2};
        tv[3]  = '{4,  3'b100, 1'b0, 2'd3};
        tv[4]  = '{4,  3'b100, 1'b0, 2'd0};
        tv[5]  = '{8,  3'b100, 1'b0, 2'd2};
        tv[6]  = '{3,  3'b100, 1'b0, 2'd2};
        tv[7]  = '{1,  3'b000, 1'b0, 2'd0};
        tv[8]  = '{3,  3'b000, 1'b0, 2'd0};
        tv[9]  = '{1,  3'b000, 1'b0, 2'd1};
        tv[10] = '{10, 3'b000, 1'b1, 2'd1};
        tv[11] = '{1,  3'b001, 1'b1, 2'd0};
        tv[12] = '{4,  3'b001, 1'b0, 2'd1};
        tv[13] = '{1,  3'b011, 1'b0, 2'd0};
        tv[14] = '{12, 3'b011, 1'b0, 2'd0};
        tv[15] = '{1,  3'b101, 1'b0, 2'd0};
        tv[16] = '{4,  3'b101, 1'b0, 2'd1};

        // {state, x, y, rom override, override colour, rom_addr, rom_set, in range}
        pv[0]  = '{3'b001, 6'd0,  7'd2,  1'b1, 12'h000, 14'd94,   2'd0, 1'b1};
        pv[1]  = '{3'b001, 6'd0,  7'd2,  1'b1, 12'hF00, 14'd94,   2'd0, 1'b1};
        pv[2]  = '{3'b000, 6'd0,  7'd2,  1'b0, 12'h000, 14'd140,  2'd0, 1'b1};
        pv[3]  = '{3'b101, 6'd46, 7'd63, 1'b0, 12'h000, 14'd3007, 2'd1, 1'b1};
        pv[4]  = '{3'b100, 6'd46, 7'd63, 1'b0, 12'h000, 14'd2961, 2'd1, 1'b1};
        pv[5]  = '{3'b011, 6'd10, 7'd5,  1'b0, 12'h000, 14'd245,  2'd2, 1'b1};
        pv[6]  = '{3'b010, 6'd10, 7'd5,  1'b0, 12'h000, 14'd271,  2'd2, 1'b1};
        pv[7]  = '{3'b001, 6'd0,  7'd0,  1'b0, 12'h000, 14'd0,    2'd0, 1'b1};
        pv[8]  = '{3'b000, 6'd0,  7'd0,  1'b0, 12'h000, 14'd46,   2'd0, 1'b1};
        pv[9]  = '{3'b001, 6'd47, 7'd3,  1'b0, 12'h000, 14'd46,   2'd0, 1'b0};
        pv[10] = '{3'b001, 6'd5,  7'd64, 1'b0, 12'h000, 14'd46,   2'd0, 1'b0};
        pv[11] = '{3'b101, 6'd20, 7'd1,  1'b0, 12'h000, 14'd67,   2'd1, 1'b1};

        bx = '{6'd0, 6'd1, 6'd2};
        by = '{7'd0, 7'd0, 7'd1};
        ba = '{14'd0, 14'd1, 14'd49};

        // Reset state
        rst_n = 1'b0;
        state = 3'b100;
        repeat (3) @(negedge clk);
        check("reset rom_addr",   32'(rom_addr),   32'd0);
        check("reset rom_set",    32'(rom_set),    32'd0);
        check("reset rom_frame",  32'(rom_frame),  32'd0);
        check("reset frame_idx",  32'(frame_idx),  32'd0);
        check("reset pix_out",    32'(pix_out),    32'd0);
        check("reset pix_valid",  32'(pix_valid),  32'd0);
        check("reset pix_opaque", 32'(pix_opaque), 32'd0);
        rst_n = 1'b1;

        // Timer: stepping, restart on tick, hold, jump
        for (int i = 0; i < NTV; i++) begin
            state = tv[i].st;
            hold  = tv[i].hold;
            repeat (tv[i].n) @(negedge clk);
            check($sformatf("timer[%0d] frame_idx", i), 32'(frame_idx), 32'(tv[i].frame));
        end
        hold = 1'b0;

        // Single pixels: address, mirroring, latency, transparency, out of range
        for (int i = 0; i < NPV; i++) begin
            state       = pv[i].st;
            rom_ovr_en  = pv[i].ovr;
            rom_ovr_val = pv[i].ovr_val;
            @(negedge clk);
            pix_req = 1'b1;
            pix_x   = pv[i].x;
            pix_y   = pv[i].y;
            exp_out = !pv[i].inr ? 12'h000 : (pv[i].ovr ? pv[i].ovr_val : rom_fn(pv[i].addr));
            exp_opq = pv[i].inr && (exp_out != 12'h000);
            @(negedge clk);
            pix_req = 1'b0;
            check($sformatf("pix[%0d] rom_addr", i), 32'(rom_addr), 32'(pv[i].addr));
            if (pv[i].inr) check($sformatf("pix[%0d] rom_set", i), 32'(rom_set), 32'(pv[i].set));
            @(negedge clk);
            check($sformatf("pix[%0d] early valid", i), 32'(pix_valid), 32'd0);
            @(negedge clk);
            check($sformatf("pix[%0d] pix_valid", i),  32'(pix_valid),  32'd1);
            check($sformatf("pix[%0d] pix_out", i),    32'(pix_out),    32'(exp_out));
            check($sformatf("pix[%0d] pix_opaque", i), 32'(pix_opaque), 32'(exp_opq));
            @(negedge clk);
            check($sformatf("pix[%0d] valid drop", i), 32'(pix_valid), 32'd0);
            check($sformatf("pix[%0d] out hold", i),   32'(pix_out),   32'(exp_out));
        end
        rom_ovr_en = 1'b0;

        // Back-to-back requests, one pixel per cycle
        state = 3'b001;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            if (k >= 3 && k <= 5) begin
                check($sformatf("b2b[%0d] pix_valid", k),  32'(pix_valid),  32'd1);
                check($sformatf("b2b[%0d] pix_out", k),    32'(pix_out),    32'(rom_fn(ba[k-3])));
                check($sformatf("b2b[%0d] pix_opaque", k), 32'(pix_opaque),
                      32'(rom_fn(ba[k-3]) != 12'h000));
            end else begin
                check($sformatf("b2b[%0d] idle valid", k), 32'(pix_valid), 32'd0);
            end
            if (k == 6) check("b2b out hold", 32'(pix_out), 32'(rom_fn(ba[2])));
            if (k >= 1 && k <= 3) check($sformatf("b2b[%0d] rom_addr", k), 32'(rom_addr), 32'(ba[k-1]));
            if (k < 3) begin
                pix_req = 1'b1;
                pix_x   = bx[k];
                pix_y   = by[k];
            end else begin
                pix_req = 1'b0;
            end
            @(negedge clk);
        end

        // Reset with three pixels in flight
        state = 3'b101;
        for (int k = 0; k < 3; k++) begin
            pix_req = 1'b1;
            pix_x   = 6'(k + 3);
            pix_y   = 7'd1;
            if (k == 2) rst_n = 1'b0;
            @(negedge clk);
        end
        pix_req = 1'b0;
        check("midrst pix_valid",  32'(pix_valid),  32'd0);
        check("midrst pix_out",    32'(pix_out),    32'd0);
        check("midrst pix_opaque", 32'(pix_opaque), 32'd0);
        check("midrst rom_addr",   32'(rom_addr),   32'd0);
        check("midrst rom_set",    32'(rom_set),    32'd0);
        check("midrst rom_frame",  32'(rom_frame),  32'd0);
        check("midrst frame_idx",  32'(frame_idx),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("postrst[%0d] pix_valid", k), 32'(pix_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sprite_anim_ctrl.md
Name: sprite_anim_ctrl

Overview:
Parametrised character-sprite animation controller for the VGA layer. It replaces per-character hard-wired frame muxes with one reusable engine. Per pixel request it selects an animation set (stand / walk / jump) and a frame index from character state. It generates a mirrored or unmirrored sprite-ROM address with no divider, then realigns the returned ROM pixel with a valid strobe and a transparency flag. One instance serves each character; the ROM bank stays outside the block.

Parameters:
SPR_W, 47, sprite width in pixels
SPR_H, 64, sprite height in pixels
ADDR_W, 14, ROM address width; must satisfy SPR_W*SPR_H <= 2**ADDR_W
N_FRAMES, 4, frames per stand/walk animation (>=1)
TICK_DIV, 6000000, clk cycles per animation frame (>=2)
ROM_LAT, 1, rom_data latency in cycles after rom_addr (>=1)
COLOR_W, 12, pixel colour width
KEY_COLOR, 12'h000, colour treated as transparent

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
state  in  3  bit0 facing (0 left, 1 right); bit1 airborne; bit2 moving
hold  in  1  1 = freeze animation timing (pause)
pix_req  in  1  pixel request strobe
pix_x  in  $clog2(SPR_W+1)  column inside sprite box
pix_y  in  $clog2(SPR_H+1)  row inside sprite box
rom_addr  out  ADDR_W  sprite ROM address
rom_set  out  2  0 stand, 1 walk, 2 jump (ROM bank select)
rom_frame  out  $clog2(N_FRAMES)  frame select to ROM bank
rom_data  in  COLOR_W  ROM pixel, valid ROM_LAT cycles after rom_addr
pix_out  out  COLOR_W  pixel colour
pix_valid  out  1  pix_out valid
pix_opaque  out  1  1 = draw, 0 = transparent
frame_idx  out  $clog2(N_FRAMES)  current animation frame (debug/status)

Behaviour:
- Reset (rst_n=0 at clk edge): tick_cnt=0, frame_idx=0, anim_set=stand, rom_addr=0, rom_set=0, rom_frame=0, pipeline valids cleared, pix_out=0, pix_valid=0, pix_opaque=0. Reset mid-pipeline drops all in-flight pixels; no valid is emitted for them.
- Set decode, combinational from state: bit1=1 -> jump; else bit2=1 -> walk; else stand.
- Tick counter: counts 0..TICK_DIV-1 while hold=0 and wraps. The terminal count is the frame tick. hold=1 freezes both the counter and frame_idx.
- Frame index:
  - Stand/walk: increments on tick and wraps N_FRAMES-1 -> 0.
  - Jump: frame_idx is forced to 0.
- Restart: the block registers set and facing every cycle. If either differs from the previous cycle, tick_cnt and frame_idx load 0 on that edge.
  - Restart overrides a simultaneous tick.
  - Restart takes effect even when hold=1.
- Address stage, 1 cycle after pix_req: rom_addr = pix_y*SPR_W + (facing ? pix_x : SPR_W-1-pix_x).
  - Constant multiply only; no divide or modulo.
  - rom_set and rom_frame register together with rom_addr. A frame change after the request never mixes into that pixel.
- Out of range (pix_x>=SPR_W or pix_y>=SPR_H): rom_addr holds its previous value. The pixel still propagates and emerges as pix_valid=1, pix_out=0, pix_opaque=0.
- Output stage: pix_valid asserts exactly 2+ROM_LAT cycles after pix_req. pix_out=rom_data; pix_opaque = in-range AND rom_data!=KEY_COLOR.
- Back-to-back pix_req is fully pipelined, one pixel per cycle. pix_valid=0 in all other cycles, and pix_out then holds its last value.

Decomposition:
- Shared package sprite_pkg holds:
  - state bit positions (ST_FACE=0, ST_AIR=1, ST_MOVE=2);
  - anim set enum (SET_STAND=0, SET_WALK=1, SET_JUMP=2);
  - default KEY_COLOR.
- One natural sub-module, anim_timer: tick counter, frame index, restart and hold logic. It exposes frame_idx and anim_set.
- The top level holds address generation and the latency-matching valid/in-range shift register, which is ROM_LAT+2 deep.

Test Plan:
1. Timer: TICK_DIV=4, N_FRAMES=4, state=3'b100 (walk left), hold=0 -> frame_idx steps every 4 cycles: 0,1,2,3,0.
2. Mirror: facing=1, x=0, y=2 -> rom_addr=94. facing=0, same x/y -> rom_addr=140. Each appears 1 cycle after pix_req.
3. Latency/transparency: ROM_LAT=1, rom_data=12'h000, then 12'hF00. Expect pix_valid at req+3 both times; opaque=0, then opaque=1 with pix_out=F00.
4. Restart: walk at frame_idx=2, state switches to 3'b000 on a tick cycle -> next cycle frame_idx=0 and tick_cnt=0. Jump (bit1=1) keeps frame_idx=0 across many ticks.
5. Hold: hold=1 for 10 cycles at frame 1 -> frame_idx stays 1. A facing change during hold -> frame_idx=0.
6. Edge cases:
   - pix_x=SPR_W -> pix_valid=1, opaque=0, rom_addr unchanged.
   - rst_n=0 with 3 pixels in flight -> no pix_valid afterwards and all outputs 0.
